// File: rtl/motoro3_regfile.sv
// motoro3_regfile - writable control-register block for the 3-phase motor driver
//
// The host writes four shadow registers: speed, power, pwmLen and pwmMin.
// Shadow values reach the live outputs only when the PWM generator signals a
// period wrap, so a PWM period never sees a half-applied configuration.
//
// Optional feature macro: M3R_SPEED_RAMP_EN
//   defined   - the live speed slews toward the committed target in steps of
//               RAMP_STEP counts, one step every RAMP_DIV clocks
//   undefined - the live speed loads the target directly at commit, and
//               m3r_ramp_busy is tied low
//
// Ports
//   clk, nRst              system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  one-cycle write into a shadow register
//                          (0 speed, 1 power, 2 pwmLen, 3 pwmMin)
//   rd_addr/rd_data        registered read of a shadow register, zero-extended
//   pwm_period_end         commit strobe from the PWM generator
//   m3r_*                  live outputs to the step/PWM generators
module motoro3_regfile #(
  parameter int SPD_W     = 25,
  parameter int PWR_W     = 8,
  parameter int PWM_W     = 12,
  parameter int SPD_RST   = 1_666_667,
  parameter int PWR_RST   = 'h10,
  parameter int LEN_RST   = 512,
  parameter int MIN_RST   = 32,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 1024
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [SPD_W-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [SPD_W-1:0] rd_data,
  input  logic             pwm_period_end,
  output logic [SPD_W-1:0] m3r_stepCNT_speedSET,
  output logic [PWR_W-1:0] m3r_power_percent,
  output logic [PWM_W-1:0] m3r_pwmLenWant,
  output logic [PWM_W-1:0] m3r_pwmMinMask,
  output logic             m3r_ramp_busy
);

  localparam logic [SPD_W-1:0] SPD_RST_V = SPD_W'(SPD_RST);
  localparam logic [PWR_W-1:0] PWR_RST_V = PWR_W'(PWR_RST);
  localparam logic [PWM_W-1:0] LEN_RST_V = PWM_W'(LEN_RST);
  localparam logic [PWM_W-1:0] MIN_RST_V = PWM_W'(MIN_RST);

  logic [SPD_W-1:0] sh_speed;
  logic [PWR_W-1:0] sh_power;
  logic [PWM_W-1:0] sh_len;
  logic [PWM_W-1:0] sh_min;

  logic [SPD_W-1:0] nxt_speed;
  logic [PWR_W-1:0] nxt_power;
  logic [PWM_W-1:0] nxt_len;
  logic [PWM_W-1:0] nxt_min;
  logic [PWM_W-1:0] commit_len;

  // Shadow contents after this cycle's write, clamps included. The commit
  // path uses these values too, so a write landing in the same cycle as a
  // period wrap is part of that commit.
  always_comb begin
    nxt_speed = sh_speed;
    nxt_power = sh_power;
    nxt_len   = sh_len;
    nxt_min   = sh_min;
    if (wr_en) begin
      case (wr_addr)
        2'd0: nxt_speed = (wr_data == '0) ? SPD_W'(1) : wr_data;
        2'd1: nxt_power = (wr_data[PWR_W-1:0] == '0) ? PWR_W'(1) : wr_data[PWR_W-1:0];
        2'd2: nxt_len   = wr_data[PWM_W-1:0];
        default: nxt_min = (wr_data[PWM_W-1:0] < MIN_RST_V) ? MIN_RST_V : wr_data[PWM_W-1:0];
      endcase
    end
    // The period must be at least as long as the minimum on-time.
    commit_len = (nxt_len < nxt_min) ? nxt_min : nxt_len;
  end

  // Shadow registers hold whatever the host last wrote.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sh_speed <= SPD_RST_V;
      sh_power <= PWR_RST_V;
      sh_len   <= LEN_RST_V;
      sh_min   <= MIN_RST_V;
    end else begin
      sh_speed <= nxt_speed;
      sh_power <= nxt_power;
      sh_len   <= nxt_len;
      sh_min   <= nxt_min;
    end
  end

  // Read port samples the shadow as it stood before this edge, so a write
  // becomes visible to reads issued from the following cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rd_data <= '0;
    end else begin
      case (rd_addr)
        2'd0: rd_data <= sh_speed;
        2'd1: rd_data <= SPD_W'(sh_power);
        2'd2: rd_data <= SPD_W'(sh_len);
        default: rd_data <= SPD_W'(sh_min);
      endcase
    end
  end

  // Power and PWM shape outputs change only at a period wrap.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m3r_power_percent <= PWR_RST_V;
      m3r_pwmLenWant    <= LEN_RST_V;
      m3r_pwmMinMask    <= MIN_RST_V;
    end else if (pwm_period_end) begin
      m3r_power_percent <= nxt_power;
      m3r_pwmLenWant    <= commit_len;
      m3r_pwmMinMask    <= nxt_min;
    end
  end

`ifdef M3R_SPEED_RAMP_EN
  localparam int CNT_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [SPD_W-1:0] STEP_V    = SPD_W'(RAMP_STEP);

  logic [SPD_W-1:0] target;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [SPD_W-1:0] ramp_next;

  // One ramp step: move by STEP_V, but land exactly on the target when the
  // remaining gap is small so the live value never overshoots or wraps.
  always_comb begin
    tick      = (tick_cnt == TICK_LAST);
    ramp_next = m3r_stepCNT_speedSET;
    if (target > m3r_stepCNT_speedSET) begin
      if ((target - m3r_stepCNT_speedSET) <= STEP_V) ramp_next = target;
      else ramp_next = m3r_stepCNT_speedSET + STEP_V;
    end else if (target < m3r_stepCNT_speedSET) begin
      if ((m3r_stepCNT_speedSET - target) <= STEP_V) ramp_next = target;
      else ramp_next = m3r_stepCNT_speedSET - STEP_V;
    end
  end

  // Free-running tick phase, committed target and slewing live speed. A new
  // target redirects the ramp from wherever live currently is; the tick
  // phase keeps running undisturbed.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tick_cnt             <= '0;
      target               <= SPD_RST_V;
      m3r_stepCNT_speedSET <= SPD_RST_V;
      m3r_ramp_busy        <= 1'b0;
    end else begin
      tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;
      m3r_ramp_busy <= (m3r_stepCNT_speedSET != target);
      if (tick) m3r_stepCNT_speedSET <= ramp_next;
      if (pwm_period_end) target <= nxt_speed;
    end
  end
`else
  // Without the ramp the live speed is the committed target itself.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m3r_stepCNT_speedSET <= SPD_RST_V;
    end else if (pwm_period_end) begin
      m3r_stepCNT_speedSET <= nxt_speed;
    end
  end

  assign m3r_ramp_busy = 1'b0;
`endif

endmodule

// File: doc/motoro3_regfile.md
# motoro3_regfile

Writable, parametrised control-register block for the 3-phase motor driver. It replaces the fixed constant register set with four software-writable shadow registers. Shadow values commit to the live outputs only at PWM-period boundaries, so the PWM generator never sees a mid-period change. The speed setpoint optionally slews toward its target (soft start / soft stop). Sits between the host write bus and the step/PWM generators; the output names are unchanged, so downstream blocks connect as before.

## Interface
- SPD_W, 25, width of step-count speed setpoint
- PWR_W, 8, width of power percent
- PWM_W, 12, width of PWM length / min-mask
- SPD_RST, 1_666_667, reset speed setpoint (1 Hz at 10 MHz)
- PWR_RST, 8'h10, reset power percent
- LEN_RST, 512, reset PWM length
- MIN_RST, 32, reset PWM min mask; also the hard floor for min mask
- RAMP_DIV, 1024, clocks between speed ramp steps (≥2)
- RAMP_STEP, 1024, max speed-count change per ramp step (≥1)

Ports:
- clk  in  1  system clock, 10 MHz
- nRst  in  1  asynchronous active-low reset
- wr_en  in  1  one-cycle write strobe
- wr_addr  in  2  0 = speed, 1 = power, 2 = pwmLen, 3 = pwmMin
- wr_data  in  SPD_W  write data; LSBs used for narrower registers
- rd_addr  in  2  read address, same map
- rd_data  out  SPD_W  shadow value at rd_addr, zero-extended
- pwm_period_end  in  1  one-cycle pulse from the PWM generator at period wrap
- m3r_stepCNT_speedSET  out  SPD_W  live (ramped) speed count
- m3r_power_percent  out  PWR_W  live power percent
- m3r_pwmLenWant  out  PWM_W  live PWM period length
- m3r_pwmMinMask  out  PWM_W  live PWM min on-time
- m3r_ramp_busy  out  1  high while live speed ≠ committed speed target

## Operation
- Write clamps applied when the shadow register is loaded:
  - speed 0 → 1
  - power 0 → 1
  - pwmMin < MIN_RST → MIN_RST
- Commit on pwm_period_end:
  - power, pwmLen and pwmMin outputs load from shadow.
  - Speed target register loads from shadow.
  - If shadow pwmLen < shadow pwmMin, pwmLenWant loads pwmMin instead (min on-time never exceeds period).
- Same-cycle wr_en and pwm_period_end: the write lands in shadow and is included in that commit.
- Ramp tick: free-running counter, 0..RAMP_DIV-1, cleared by reset; a tick fires on its wrap. On each tick with live ≠ target:
  - live moves toward target by RAMP_STEP.
  - If |target − live| ≤ RAMP_STEP, live = target exactly (no overshoot, no underflow, no wrap).
- A target change mid-ramp redirects the ramp from the current live value; the tick phase is not reset.
- m3r_ramp_busy = (live ≠ target), registered.
- Reset: all shadow, target and live registers take their *_RST values; the tick counter is 0; rd_data is 0; m3r_ramp_busy is 0.

## Timing
- wr_en at cycle N: shadow updated at N+1. rd_data reflects rd_addr sampled at N, valid at N+1 (1-cycle read latency, write visible on read from N+1).
- pwm_period_end at cycle N: power/len/min outputs and speed target change at N+1.
- Ramp: first live step at the first tick at or after N+1; the step is visible the cycle after the tick.
- m3r_ramp_busy rises at N+2 after a commit that changes the target. It falls the cycle after live reaches target.
- Asserting nRst mid-ramp or mid-commit forces reset values immediately (asynchronous); no partial commit survives.

## Configuration
- M3R_SPEED_RAMP_EN defined: speed ramp as above.
- M3R_SPEED_RAMP_EN undefined: live speed loads the target directly at commit, the tick counter is removed, and m3r_ramp_busy is tied 0. RAMP_DIV and RAMP_STEP are ignored.

## Test plan
- Reset → outputs 1_666_667 / 8'h10 / 512 / 32, busy 0; read addr 0 returns 1_666_667 one cycle later.
- Write power = 0x40, no period end for 100 cycles → m3r_power_percent stays 0x10, read returns 0x40; pulse pwm_period_end → output 0x40 the next cycle.
- Write power = 0, pwmMin = 8, pwmLen = 16, then commit → power 1, min 32, len 32.
- Ramp enabled, RAMP_DIV = 4, RAMP_STEP = 1000, commit speed 1_664_167 from 1_666_667 → live drops by 1000 every 4 clocks. Last step is 500, landing exactly on 1_664_167, then busy falls.
- Write and pwm_period_end in the same cycle with speed 20_000 → target 20_000 committed. A second target of 30_000 committed mid-ramp → live reverses from its current value without overshoot.
- Assert nRst during ramp → all outputs return to reset values asynchronously. Build without M3R_SPEED_RAMP_EN → speed output jumps to target at N+1, busy always 0.
